// File: rtl/bsg_wrr_packet_arb_n_to_1_pkg.sv
// Shared definitions for the weighted round-robin packet arbiter.
package bsg_wrr_packet_arb_n_to_1_pkg;

    typedef enum logic {
        BOUNDARY = 1'b0,
        LOCKED   = 1'b1
    } pkt_state_e;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_wrr_packet_arb_n_to_1_rr_rotate_pick.sv
// Rotating priority pick: first set request at or after start_i, wrapping modulo num_in_p.
module bsg_rr_rotate_pick
    import bsg_wrr_packet_arb_n_to_1_pkg::*;
#(
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned tag_width_lp = safe_clog2(num_in_p)
) (
    input  logic [num_in_p-1:0]     reqs_i,
    input  logic [tag_width_lp-1:0] start_i,
    output logic [num_in_p-1:0]     grant_o,
    output logic [tag_width_lp-1:0] addr_o,
    output logic                    v_o
);

    logic [2*num_in_p-1:0] doubled;
    logic [num_in_p-1:0]   rotated;
    logic                  found;
    int unsigned           idx;

    // Doubling the vector turns the wrap-around scan into a plain lowest-bit search.
    always_comb begin
        doubled = {reqs_i, reqs_i};
        rotated = num_in_p'(doubled >> start_i);
        grant_o = '0;
        addr_o  = '0;
        v_o     = |reqs_i;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                idx   = 32'(start_i) + i;
                if (idx >= num_in_p) begin
                    idx = idx - num_in_p;
                end
                addr_o  = tag_width_lp'(idx);
                grant_o = num_in_p'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/bsg_wrr_packet_arb_n_to_1.sv
// Packet-aware weighted round-robin merge of num_in_p FIFO heads onto one valid/yumi channel.
module bsg_wrr_packet_arb_n_to_1
    import bsg_wrr_packet_arb_n_to_1_pkg::*;
#(
    parameter int unsigned width_p       = 8,
    parameter int unsigned num_in_p      = 4,
    parameter int unsigned quota_width_p = 4,
    parameter int unsigned tag_width_lp  = safe_clog2(num_in_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_in_p*width_p-1:0]       data_i,
    input  logic [num_in_p-1:0]               v_i,
    input  logic [num_in_p-1:0]               last_i,
    input  logic [num_in_p*quota_width_p-1:0] quota_i,
    output logic [num_in_p-1:0]               yumi_o,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    output logic                              last_o,
    output logic [tag_width_lp-1:0]           tag_o,
    input  logic                              yumi_i
);

    localparam logic [tag_width_lp-1:0] last_idx_lp = tag_width_lp'(num_in_p - 1);

    pkt_state_e                in_pkt_r, in_pkt_n;
    logic [tag_width_lp-1:0]   owner_r, owner_n;
    logic [quota_width_p-1:0]  credit_r, credit_n;

    logic [tag_width_lp-1:0]   start_c, pick_addr_c, sel_c;
    logic [num_in_p-1:0]       pick_grant_c, sel_oh_c;
    logic                      pick_v_c, cont_c;
    logic [quota_width_p-1:0]  quota_sel_c;

    assign start_c = (owner_r == last_idx_lp) ? '0 : owner_r + tag_width_lp'(1);

    bsg_rr_rotate_pick #(
        .num_in_p     (num_in_p),
        .tag_width_lp (tag_width_lp)
    ) rotate_pick (
        .reqs_i  (v_i),
        .start_i (start_c),
        .grant_o (pick_grant_c),
        .addr_o  (pick_addr_c),
        .v_o     (pick_v_c)
    );

    // Grant selection: locked owner, continuing owner with credit, or next in rotation.
    always_comb begin
        cont_c = (in_pkt_r == BOUNDARY) && (credit_r != '0) && v_i[owner_r];
        if ((in_pkt_r == LOCKED) || cont_c) begin
            sel_c    = owner_r;
            sel_oh_c = num_in_p'(1) << owner_r;
        end else begin
            sel_c    = pick_addr_c;
            sel_oh_c = pick_grant_c;
        end
        v_o         = (in_pkt_r == LOCKED) ? v_i[owner_r] : pick_v_c;
        tag_o       = sel_c;
        yumi_o      = sel_oh_c & {num_in_p{yumi_i}};
        last_o      = |(last_i & sel_oh_c);
        quota_sel_c = quota_i[32'(sel_c)*quota_width_p +: quota_width_p];
    end

    // One-hot AND-OR data mux.
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            data_o = data_o | (data_i[i*width_p +: width_p] & {width_p{sel_oh_c[i]}});
        end
    end

    always_comb begin
        in_pkt_n = in_pkt_r;
        owner_n  = owner_r;
        credit_n = credit_r;
        if (yumi_i) begin
            if (in_pkt_r == BOUNDARY) begin
                owner_n = sel_c;
                if (cont_c) begin
                    credit_n = credit_r - quota_width_p'(1);
                end else begin
                    // A zero quota behaves as one packet per turn.
                    credit_n = (quota_sel_c == '0) ? '0 : quota_sel_c - quota_width_p'(1);
                end
                in_pkt_n = last_o ? BOUNDARY : LOCKED;
            end else if (last_o) begin
                in_pkt_n = BOUNDARY;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_pkt_r <= BOUNDARY;
            owner_r  <= last_idx_lp;
            credit_r <= '0;
        end else begin
            in_pkt_r <= in_pkt_n;
            owner_r  <= owner_n;
            credit_r <= credit_n;
        end
    end

`ifndef SYNTHESIS
    logic [num_in_p*quota_width_p-1:0] quota_q;

    always_ff @(posedge clk_i) begin
        quota_q <= quota_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
            assert ($onehot0(yumi_o)) else $error("yumi_o is not one-hot");
            if (in_pkt_r == LOCKED) begin
                assert (quota_i == quota_q) else $error("quota_i changed inside a packet");
            end
        end
    end
`endif

endmodule
